// File: rtl/ifctl_pkg.sv
// Shared definitions for the CPU-side system-bus interface controller:
// bus-cycle state encoding and the answer priority decode.
package ifctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_STRB = 3'd3,
    ST_REL  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ANS_NONE = 2'd0,
    ANS_OK   = 2'd1,
    ANS_EN   = 2'd2,
    ANS_PE   = 2'd3
  } ans_t;

  // Parity error beats engaged, engaged beats OK when several answers coincide.
  function automatic ans_t ans_pick(input logic pe, input logic en, input logic ok);
    ans_t a;
    if (pe) begin
      a = ANS_PE;
    end else if (en) begin
      a = ANS_EN;
    end else if (ok) begin
      a = ANS_OK;
    end else begin
      a = ANS_NONE;
    end
    return a;
  endfunction

endpackage

// File: rtl/ifctl_timer.sv
// Clear/enable saturating counter; tc_o flags the last tick before the timeout.
module if_timer #(
  parameter int TICKS = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(TICKS) + 1;
  localparam logic [W-1:0] TC_VAL  = W'(TICKS - 1);
  localparam logic [W-1:0] SAT_VAL = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT_VAL)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ifctl.sv
// CPU-side system-bus interface controller: runs one request/grant, address,
// strobe, answer, release cycle per accepted transfer, with EN retries and timeout.
module ifctl
  import ifctl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64,
  parameter int RETRY_MAX     = 4
) (
  input  logic        __clk,
  input  logic        clm,
  input  logic        req,
  input  logic        wr,
  input  logic        io,
  input  logic [15:0] addr,
  input  logic [15:0] dout,
  output logic [15:0] din,
  output logic        zw,
  output logic        oken,
  output logic        ok$,
  output logic        alarm_na,
  output logic        alarm_pe,
  output logic        alarm_en,
  output logic        breq,
  input  logic        bgnt,
  output logic [15:0] bus_a,
  output logic [15:0] bus_d_o,
  input  logic [15:0] bus_d_i,
  output logic        bus_w,
  output logic        bus_r,
  output logic        bus_io,
  input  logic        ans_ok,
  input  logic        ans_en,
  input  logic        ans_pe
);

  localparam int RW = $clog2(RETRY_MAX) + 1;
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  state_t        state_q, state_d;
  logic          wr_q, wr_d, io_q, io_d;
  logic [15:0]   addr_q, addr_d, dat_q, dat_d, din_q, din_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d, tmo_q, tmo_d;
  logic          ok_q, ok_d, oken_q, oken_d;
  logic          na_q, na_d, pe_q, pe_d, en_q, en_d;
  logic          zw_q, breq_q, bus_w_q, bus_r_q, bus_io_q;
  logic [15:0]   bus_a_q, bus_d_q;
  logic          tc_s, drive_s, any_ans_s;
  ans_t          ans_s;

  assign ans_s     = ans_pick(ans_pe, ans_en, ans_ok);
  assign any_ans_s = ans_pe | ans_en | ans_ok;
  assign drive_s   = (state_d == ST_ADDR) || (state_d == ST_STRB) || (state_d == ST_REL);

  if_timer #(.TICKS(TIMEOUT_TICKS)) u_timer (
    .clk_i (__clk),
    .rst_i (clm),
    .clr_i (state_q != ST_STRB),
    .en_i  (state_q == ST_STRB),
    .tc_o  (tc_s)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    io_d    = io_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    din_d   = din_q;
    retry_d = retry_q;
    pend_d  = pend_q;
    tmo_d   = 1'b0;
    ok_d    = ok_q;
    oken_d  = oken_q;
    na_d    = 1'b0;
    pe_d    = 1'b0;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_REQ;
          wr_d    = wr;
          io_d    = io;
          addr_d  = addr;
          dat_d   = dout;
          retry_d = '0;
          pend_d  = 1'b0;
          ok_d    = 1'b0;
          oken_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bgnt) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_ADDR: state_d = ST_STRB;
      ST_STRB: begin
        case (ans_s)
          ANS_PE: begin
            state_d = ST_REL;
            pe_d    = 1'b1;
            oken_d  = 1'b0;
            pend_d  = 1'b0;
          end
          ANS_EN: begin
            state_d = ST_REL;
            if (retry_q != RMAX) begin
              retry_d = retry_q + RW'(1);
            end else begin
              retry_d = retry_q;
            end
            // The attempt that brings the count to RETRY_MAX is the last one.
            if (retry_q == (RMAX - RW'(1))) begin
              en_d   = 1'b1;
              oken_d = 1'b0;
              pend_d = 1'b0;
            end else begin
              pend_d = 1'b1;
            end
          end
          ANS_OK: begin
            state_d = ST_REL;
            ok_d    = 1'b1;
            oken_d  = 1'b0;
            pend_d  = 1'b0;
            if (!wr_q) begin
              din_d = bus_d_i;
            end else begin
              din_d = din_q;
            end
          end
          default: begin
            if (tc_s) begin
              state_d = ST_REL;
              na_d    = 1'b1;
              tmo_d   = 1'b1;
              oken_d  = 1'b0;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_STRB;
            end
          end
        endcase
      end
      ST_REL: begin
        if (tmo_q || !any_ans_s) begin
          state_d = pend_q ? ST_ADDR : ST_DONE;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_REL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        oken_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        oken_d  = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so the bus changes on the transition edge.
  always_ff @(posedge __clk) begin
    if (clm) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= 16'h0000;
      dat_q    <= 16'h0000;
      din_q    <= 16'h0000;
      retry_q  <= '0;
      pend_q   <= 1'b0;
      tmo_q    <= 1'b0;
      ok_q     <= 1'b0;
      oken_q   <= 1'b0;
      na_q     <= 1'b0;
      pe_q     <= 1'b0;
      en_q     <= 1'b0;
      zw_q     <= 1'b0;
      breq_q   <= 1'b0;
      bus_a_q  <= 16'h0000;
      bus_d_q  <= 16'h0000;
      bus_w_q  <= 1'b0;
      bus_r_q  <= 1'b0;
      bus_io_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      din_q    <= din_d;
      retry_q  <= retry_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      ok_q     <= ok_d;
      oken_q   <= oken_d;
      na_q     <= na_d;
      pe_q     <= pe_d;
      en_q     <= en_d;
      zw_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      breq_q   <= drive_s || (state_d == ST_REQ);
      bus_a_q  <= drive_s ? addr_d : 16'h0000;
      bus_d_q  <= (drive_s && wr_d) ? dat_d : 16'h0000;
      bus_w_q  <= (state_d == ST_STRB) && wr_d;
      bus_r_q  <= (state_d == ST_STRB) && !wr_d;
      bus_io_q <= drive_s && io_d;
    end
  end

  assign din      = din_q;
  assign zw       = zw_q;
  assign oken     = oken_q;
  assign ok$      = ok_q;
  assign alarm_na = na_q;
  assign alarm_pe = pe_q;
  assign alarm_en = en_q;
  assign breq     = breq_q;
  assign bus_a    = bus_a_q;
  assign bus_d_o  = bus_d_q;
  assign bus_w    = bus_w_q;
  assign bus_r    = bus_r_q;
  assign bus_io   = bus_io_q;

endmodule

// File: tb/tb_ifctl.sv
// Directed, table-driven bench for ifctl: each record is one transfer with its
// bus responder behaviour and the hand-computed outcome.
module tb_ifctl;

  localparam int TO = 64;
  localparam int RM = 4;

  typedef enum int {FIN_OK, FIN_PE, FIN_PEOK, FIN_NONE, FIN_EXH} fin_t;

  typedef struct {
    logic        wr;
    logic        io;
    logic [15:0] a;
    logic [15:0] d;
    int          gdly;
    int          adly;
    int          n_en;
    fin_t        fin;
    logic        gdrop;
    logic [15:0] rdata;
    logic [15:0] exp_din;
    logic        exp_ok;
    logic        exp_na;
    logic        exp_pe;
    logic        exp_en;
  } vec_t;

  logic        clk = 1'b0;
  logic        clm, req, wr, io, bgnt, ans_ok, ans_en, ans_pe;
  logic [15:0] addr, dout, din, bus_a, bus_d_o, bus_d_i;
  logic        zw, oken, ok_s, alarm_na, alarm_pe, alarm_en, breq, bus_w, bus_r, bus_io;

  int   tests = 0;
  int   fails = 0;
  vec_t vt[7];
  vec_t vr;

  always #5 clk = ~clk;

  ifctl #(.TIMEOUT_TICKS(TO), .RETRY_MAX(RM)) dut (
    .__clk    (clk),
    .clm      (clm),
    .req      (req),
    .wr       (wr),
    .io       (io),
    .addr     (addr),
    .dout     (dout),
    .din      (din),
    .zw       (zw),
    .oken     (oken),
    .ok$      (ok_s),
    .alarm_na (alarm_na),
    .alarm_pe (alarm_pe),
    .alarm_en (alarm_en),
    .breq     (breq),
    .bgnt     (bgnt),
    .bus_a    (bus_a),
    .bus_d_o  (bus_d_o),
    .bus_d_i  (bus_d_i),
    .bus_w    (bus_w),
    .bus_r    (bus_r),
    .bus_io   (bus_io),
    .ans_ok   (ans_ok),
    .ans_en   (ans_en),
    .ans_pe   (ans_pe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic xfer(input vec_t v);
    int strobes;
    int n;
    int attempts;
    bit last;
    attempts = v.n_en + ((v.fin == FIN_EXH) ? 0 : 1);
    strobes  = 0;
    @(negedge clk);
    req = 1'b1; wr = v.wr; io = v.io; addr = v.a; dout = v.d;
    @(negedge clk);
    req = 1'b0; wr = !v.wr; io = !v.io; addr = ~v.a; dout = ~v.d;
    chk("zw_on", zw, 1'b1);
    chk("oken_on", oken, 1'b1);
    chk("breq_on", breq, 1'b1);
    chk("ok_clr", ok_s, 1'b0);
    chk("req_bus_a_zero", bus_a, 16'h0000);
    repeat (v.gdly) @(negedge clk);
    bgnt = 1'b1;
    for (int k = 0; k < attempts; k++) begin
      last = (k == attempts - 1);
      n = 0;
      while (!(bus_w || bus_r) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("strobe_seen", bus_w | bus_r, 1'b1);
      strobes++;
      if (v.gdrop) bgnt = 1'b0;
      chk("bus_a", bus_a, v.a);
      chk("bus_io", bus_io, v.io);
      chk("bus_d_o", bus_d_o, v.wr ? v.d : 16'h0000);
      chk("bus_w", bus_w, v.wr);
      chk("bus_r", bus_r, !v.wr);
      if (last && v.fin == FIN_NONE) begin
        n = 0;
        while ((bus_w || bus_r) && n < 200) begin
          n++;
          @(negedge clk);
        end
        chk("strobe_len", n, TO);
      end else begin
        repeat (v.adly) begin
          @(negedge clk);
          chk("strb_hold", bus_w | bus_r, 1'b1);
          chk("a_hold", bus_a, v.a);
          chk("d_hold", bus_d_o, v.wr ? v.d : 16'h0000);
        end
        ans_en  = (k < v.n_en);
        ans_ok  = !(k < v.n_en) && (v.fin == FIN_OK || v.fin == FIN_PEOK);
        ans_pe  = !(k < v.n_en) && (v.fin == FIN_PE || v.fin == FIN_PEOK);
        bus_d_i = v.rdata;
        @(negedge clk);
      end
      chk("strobe_off", bus_w | bus_r, 1'b0);
      chk("rel_bus_a", bus_a, v.a);
      chk("rel_zw", zw, 1'b1);
      chk("oken_ans", oken, last ? 1'b0 : 1'b1);
      chk("alarm_na", alarm_na, last ? v.exp_na : 1'b0);
      chk("alarm_pe", alarm_pe, last ? v.exp_pe : 1'b0);
      chk("alarm_en", alarm_en, last ? v.exp_en : 1'b0);
      ans_en = 1'b0; ans_ok = 1'b0; ans_pe = 1'b0; bus_d_i = 16'h0000;
    end
    chk("strobes", strobes, attempts);
    @(negedge clk);
    chk("done_zw", zw, 1'b0);
    chk("done_breq", breq, 1'b0);
    chk("done_bus_a", bus_a, 16'h0000);
    chk("done_bus_d", bus_d_o, 16'h0000);
    chk("done_bus_io", bus_io, 1'b0);
    chk("done_oken", oken, 1'b0);
    chk("done_alarms", {alarm_na, alarm_pe, alarm_en}, 3'b000);
    chk("ok", ok_s, v.exp_ok);
    bgnt = 1'b0;
    @(negedge clk);
    chk("din", din, v.exp_din);
    chk("idle_zw", zw, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          wr    io    a         d         g  a  en fin       gdrop rdata     exp_din   ok    na    pe    en
    vt[0] = '{1'b0, 1'b0, 16'h1000, 16'h0000, 3, 2, 0, FIN_OK,   1'b0, 16'hA55A, 16'hA55A, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 16'h0123, 16'hBEEF, 0, 0, 0, FIN_OK,   1'b0, 16'h5555, 16'hA55A, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 16'h2222, 16'h0000, 1, 1, 4, FIN_EXH,  1'b0, 16'h1111, 16'hA55A, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 2, 1, 2, FIN_OK,   1'b1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h4444, 16'h0F0F, 0, 1, 0, FIN_PEOK, 1'b0, 16'h7777, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 16'h5555, 16'h0000, 1, 0, 0, FIN_PE,   1'b0, 16'h9999, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 16'h6666, 16'h0000, 0, 0, 0, FIN_NONE, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
    vr    = '{1'b0, 1'b0, 16'h0ACE, 16'h0000, 1, 1, 0, FIN_OK,   1'b0, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0};

    clm = 1'b1; req = 1'b0; wr = 1'b0; io = 1'b0; bgnt = 1'b0;
    ans_ok = 1'b0; ans_en = 1'b0; ans_pe = 1'b0;
    addr = 16'h0000; dout = 16'h0000; bus_d_i = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {zw, oken, ok_s, breq, bus_w, bus_r, bus_io, alarm_na, alarm_pe, alarm_en}, 10'h000);
    chk("rst_bus_a", bus_a, 16'h0000);
    chk("rst_din", din, 16'h0000);
    clm = 1'b0;

    for (int i = 0; i < 7; i++) begin
      xfer(vt[i]);
    end

    // Latency with immediate grant and answer; a req during the cycle is dropped.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; io = 1'b0; addr = 16'h7777; bgnt = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("lat_breq", breq, 1'b1);
    chk("lat_req_bus_a", bus_a, 16'h0000);
    @(negedge clk);
    chk("lat_addr_a", bus_a, 16'h7777);
    chk("lat_addr_strb", bus_r, 1'b0);
    @(negedge clk);
    chk("lat_strb", bus_r, 1'b1);
    req = 1'b1; addr = 16'h8888; ans_ok = 1'b1; bus_d_i = 16'h0BAD;
    @(negedge clk);
    req = 1'b0; ans_ok = 1'b0; bus_d_i = 16'h0000;
    chk("lat_oken", oken, 1'b0);
    chk("lat_ok", ok_s, 1'b1);
    chk("lat_din", din, 16'h0BAD);
    @(negedge clk);
    chk("lat_done_zw", zw, 1'b0);
    bgnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_queue", breq, 1'b0);
    end

    // Reset during the strobe drops everything on the sampling edge.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; io = 1'b1; addr = 16'h9ABC; bgnt = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int n = 0; n < 10 && !bus_r; n++) @(negedge clk);
    chk("rst_mid_strobe", bus_r, 1'b1);
    clm = 1'b1;
    @(negedge clk);
    chk("rstmid_outputs", {zw, oken, ok_s, breq, bus_w, bus_r, bus_io, alarm_na, alarm_pe, alarm_en}, 10'h000);
    chk("rstmid_bus_a", bus_a, 16'h0000);
    chk("rstmid_din", din, 16'h0000);
    clm = 1'b0; bgnt = 1'b0;
    xfer(vr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
